fb_write_arbiter: RTL and testbench

- Owns the write port of the frame-buffer dual-port RAM (addr_in / data_in / regwrite side).
- Shares that port between two game-logic requesters (A = game FSM, B = auxiliary drawer, e.g. score/overlay).
- Contains a built-in clear engine that fills the whole buffer with one colour on command.
- Sits between the game logic and the RAM, clocked by the 25 MHz pixel clock.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_write_arbiter_if.sv | 49 ++++
 rtl/fb_clear_engine.sv | 67 ++++++
 rtl/fb_write_arbiter.sv | 137 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer write path: RAM geometry, the RGB
// 1-1-1 colour constants and the arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int AW       = 15;    // frame-buffer RAM address width
    localparam int DW       = 3;     // pixel width, RGB 1-1-1
    localparam int FB_WORDS = 4800;  // 80x60 cells written by a full clear

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] pix_t;

    localparam pix_t BLACK = 3'b000;
    localparam pix_t RED   = 3'b100;
    localparam pix_t GREEN = 3'b010;
    localparam pix_t BLUE  = 3'b001;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_wr_if
// Bundle of everything that crosses the arbiter boundary except clk/rst:
//   clear_req/clear_busy   clear command and status
//   vblank                 blanking flag from the VGA timing
//   req/addr/data/gnt _a   requester A (game FSM)
//   req/addr/data/gnt _b   requester B (overlay drawer)
//   mem_addr/data/we       RAM write port
// slave  : the arbiter's view.
// master : the game-logic / RAM side (and the testbench).
// -----------------------------------------------------------------------------
interface fb_wr_if;
    import fb_pkg::*;

    logic  clear_req;
    logic  clear_busy;
    logic  vblank;

    logic  req_a;
    addr_t addr_a;
    pix_t  data_a;
    logic  gnt_a;

    logic  req_b;
    addr_t addr_b;
    pix_t  data_b;
    logic  gnt_b;

    addr_t mem_addr;
    pix_t  mem_data;
    logic  mem_we;

    modport slave (
        input  clear_req, vblank,
        input  req_a, addr_a, data_a,
        input  req_b, addr_b, data_b,
        output clear_busy, gnt_a, gnt_b,
        output mem_addr, mem_data, mem_we
    );

    modport master (
        output clear_req, vblank,
        output req_a, addr_a, data_a,
        output req_b, addr_b, data_b,
        input  clear_busy, gnt_a, gnt_b,
        input  mem_addr, mem_data, mem_we
    );

endinterface

// File: rtl/fb_clear_engine.sv
// -----------------------------------------------------------------------------
// fb_clear_engine
// Address walker for the full-buffer clear. start_i arms it at address 0; each
// cycle with step_i high it offers one write at the current address and
// advances. After FB_WORDS-1 it rewinds to 0 and goes idle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start_i    begin a clear (ignored while busy)
//   step_i     permission to write this cycle
//   busy_o     clear in progress
//   we_o       write offered this cycle
//   addr_o     address of the offered write
//   done_o     the offered write is the last one
// -----------------------------------------------------------------------------
module fb_clear_engine
    import fb_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  start_i,
    input  logic  step_i,
    output logic  busy_o,
    output logic  we_o,
    output addr_t addr_o,
    output logic  done_o
);

    addr_t cnt_q, cnt_d;
    logic  busy_q, busy_d;
    logic  last;

    assign last = (cnt_q == addr_t'(FB_WORDS - 1));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i && !busy_q) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (busy_q && step_i) begin
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + addr_t'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign we_o   = busy_q & step_i;
    assign addr_o = cnt_q;
    assign done_o = busy_q & step_i & last;

endmodule

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
// Owns the frame-buffer RAM write port and shares it between requester A,
// requester B and the built-in clear engine. All outputs are registered.
//
// Timing: a request sampled at a clock edge (with its addr/data) produces a
// one-cycle gnt after that edge and the RAM write one cycle later. The
// requester presents its next word, or drops req, during the gnt cycle, which
// allows one grant per cycle under continuous requests.
// A clear_req seen in IDLE wins over requests; a write already granted still
// lands on the port before the first clear write.
//
// Ports: clk, rst (synchronous, active-high), bus (fb_wr_if.slave).
// Parameter: CLEAR_COLOR, value written by the clear engine.
// Optional feature macro FB_WR_VBLANK_GATE_EN: grants and clear steps happen
// only while vblank=1; an already granted write still completes.
// -----------------------------------------------------------------------------
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter pix_t CLEAR_COLOR = BLACK
) (
    input  logic     clk,
    input  logic     rst,
    fb_wr_if.slave   bus
);

    state_e state_q, state_d;
    logic   prefer_b_q, prefer_b_d;   // round-robin pointer, 0 favours A
    logic   grant_a, grant_b, clear_start, wr_ok;

    logic   gnt_a_q, gnt_b_q, clear_busy_q;
    logic   pend_we_q;                // write granted last edge, lands next edge
    addr_t  pend_addr_q;
    pix_t   pend_data_q;
    logic   mem_we_q;
    addr_t  mem_addr_q;
    pix_t   mem_data_q;

    logic   eng_busy, eng_we, eng_done;
    addr_t  eng_addr;

`ifdef FB_WR_VBLANK_GATE_EN
    assign wr_ok = bus.vblank;
`else
    logic unused_vblank;
    assign unused_vblank = bus.vblank;
    assign wr_ok = 1'b1;
`endif

    fb_clear_engine u_clear (
        .clk     (clk),
        .rst     (rst),
        .start_i (clear_start),
        .step_i  (wr_ok),
        .busy_o  (eng_busy),
        .we_o    (eng_we),
        .addr_o  (eng_addr),
        .done_o  (eng_done)
    );

    always_comb begin
        state_d     = state_q;
        prefer_b_d  = prefer_b_q;
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        clear_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    state_d     = CLEAR;
                    clear_start = 1'b1;
                end else if (wr_ok) begin
                    if (bus.req_a && (!bus.req_b || !prefer_b_q)) begin
                        grant_a    = 1'b1;
                        prefer_b_d = 1'b1;
                    end else if (bus.req_b) begin
                        grant_b    = 1'b1;
                        prefer_b_d = 1'b0;
                    end
                end
            end
            CLEAR: begin
                if (eng_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prefer_b_q   <= 1'b0;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            clear_busy_q <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            prefer_b_q   <= prefer_b_d;
            gnt_a_q      <= grant_a;
            gnt_b_q      <= grant_b;
            clear_busy_q <= eng_busy;
            pend_we_q    <= grant_a | grant_b;
            if (grant_a) begin
                pend_addr_q <= bus.addr_a;
                pend_data_q <= bus.data_a;
            end else if (grant_b) begin
                pend_addr_q <= bus.addr_b;
                pend_data_q <= bus.data_b;
            end
            // A granted write and a clear write never coincide: the clear
            // engine only starts at an edge where no grant is issued.
            mem_we_q <= pend_we_q | eng_we;
            if (pend_we_q) begin
                mem_addr_q <= pend_addr_q;
                mem_data_q <= pend_data_q;
            end else if (eng_we) begin
                mem_addr_q <= eng_addr;
                mem_data_q <= CLEAR_COLOR;
            end
        end
    end

    assign bus.gnt_a      = gnt_a_q;
    assign bus.gnt_b      = gnt_b_q;
    assign bus.clear_busy = clear_busy_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_write_arbiter
// Directed bench for fb_write_arbiter. Inputs change 1 ns after a rising edge
// and outputs are read at that point, so each tick() shows the registered
// result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_fb_write_arbiter;
    import fb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    int   walk_err, busy_cnt, gnt_early, freeze_err, n_busy;
    logic found;

    fb_wr_if bus ();

    fb_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #20 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.clear_req = 1'b0;
        bus.vblank    = 1'b1;
        bus.req_a = 1'b1; bus.addr_a = 15'd7;  bus.data_a = 3'd5;
        bus.req_b = 1'b0; bus.addr_b = 15'd0;  bus.data_b = 3'd0;

        // Reset held 3 cycles with req_a high: nothing may be granted or written.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_gnt_a", bus.gnt_a, 0);
            check("rst_mem_we", bus.mem_we, 0);
        end
        check("rst_busy", bus.clear_busy, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        rst = 1'b0;
        tick();
        check("post_rst_gnt_a", bus.gnt_a, 1);
        check("post_rst_we0", bus.mem_we, 0);
        bus.req_a = 1'b0;
        tick();
        check("post_rst_we", bus.mem_we, 1);
        check("post_rst_addr", bus.mem_addr, 7);
        check("post_rst_data", bus.mem_data, 5);
        check("post_rst_gnt_off", bus.gnt_a, 0);
        tick();
        check("post_rst_idle_we", bus.mem_we, 0);

        // Reset again so the round-robin pointer favours A.
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Contention: grants alternate A,B,... and writes follow one cycle later.
        bus.req_a = 1'b1; bus.addr_a = 15'd10; bus.data_a = 3'd1;
        bus.req_b = 1'b1; bus.addr_b = 15'd20; bus.data_b = 3'd2;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("cont_gnt_a", bus.gnt_a, (i % 2 == 0) ? 1 : 0);
            check("cont_gnt_b", bus.gnt_b, (i % 2 == 1) ? 1 : 0);
            if (i > 0) begin
                check("cont_we", bus.mem_we, 1);
                check("cont_addr", bus.mem_addr, (i % 2 == 1) ? 10 : 20);
            end
        end
        bus.req_b = 1'b0;          // B saw its grant
        tick();
        check("cont_tail_gnt_a", bus.gnt_a, 1);
        check("cont_tail_addr", bus.mem_addr, 20);
        check("cont_tail_data", bus.mem_data, 2);
        bus.req_a = 1'b0;
        tick();
        check("cont_last_addr", bus.mem_addr, 10);
        check("cont_last_gnt_b", bus.gnt_b, 0);
        tick();

        // Single requester B: five words 100..104, granted every cycle.
        bus.req_b = 1'b1; bus.addr_b = 15'd100; bus.data_b = 3'd1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("single_gnt_b", bus.gnt_b, 1);
            check("single_we", bus.mem_we, (k > 0) ? 1 : 0);
            if (k > 0) begin
                check("single_addr", bus.mem_addr, 100 + k - 1);
                check("single_data", bus.mem_data, k);
            end
            if (k < 4) begin
                bus.addr_b = 15'(101 + k);
                bus.data_b = 3'(k + 2);
            end else begin
                bus.req_b = 1'b0;
            end
        end
        tick();
        check("single_end_gnt", bus.gnt_b, 0);
        check("single_end_addr", bus.mem_addr, 104);
        check("single_end_data", bus.mem_data, 5);
        tick();
        check("single_idle_we", bus.mem_we, 0);

`ifndef FB_WR_VBLANK_GATE_EN
        // Without the gate, vblank low must not block a grant.
        bus.vblank = 1'b0;
        bus.req_a = 1'b1; bus.addr_a = 15'd33; bus.data_a = 3'd4;
        tick();
        check("novb_gnt_a", bus.gnt_a, 1);
        bus.req_a = 1'b0;
        tick();
        check("novb_addr", bus.mem_addr, 33);
        check("novb_we", bus.mem_we, 1);
        tick();
        bus.vblank = 1'b1;
`endif

        // Grant outstanding for B when clear_req arrives; A starts waiting.
        bus.req_b = 1'b1; bus.addr_b = 15'd300; bus.data_b = 3'd3;
        tick();
        check("pre_clr_gnt_b", bus.gnt_b, 1);
        bus.req_b = 1'b0;
        bus.clear_req = 1'b1;
        bus.req_a = 1'b1; bus.addr_a = 15'd55; bus.data_a = 3'd6;
        tick();
        bus.clear_req = 1'b0;
        check("pre_clr_we", bus.mem_we, 1);
        check("pre_clr_addr", bus.mem_addr, 300);
        check("pre_clr_data", bus.mem_data, 3);
        check("pre_clr_gnt_a", bus.gnt_a, 0);
        check("pre_clr_busy", bus.clear_busy, 0);

        // Full clear walk; an extra clear_req mid-way must be ignored.
        walk_err = 0; busy_cnt = 0; gnt_early = 0;
        for (int t = 1; t <= 4800; t++) begin
            bus.clear_req = (t == 2000);
            tick();
            if (bus.clear_busy) busy_cnt++;
            if (bus.gnt_a || bus.gnt_b) gnt_early++;
            if (!bus.mem_we || bus.mem_addr != 15'(t - 1) || bus.mem_data != BLACK)
                walk_err++;
        end
        bus.clear_req = 1'b0;
        check("clr_walk_errs", walk_err, 0);
        check("clr_busy_cycles", busy_cnt, 4800);
        check("clr_no_grants", gnt_early, 0);
        tick();
        check("clr_busy_fall", bus.clear_busy, 0);
        check("clr_gnt_a_after", bus.gnt_a, 1);
        check("clr_after_we", bus.mem_we, 0);
        bus.req_a = 1'b0;
        tick();
        check("clr_a_write_addr", bus.mem_addr, 55);
        check("clr_a_write_data", bus.mem_data, 6);
        tick();

        // Reset in the middle of a clear, then a fresh clear from address 0.
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 1200 && !found; k++) begin
            tick();
            if (bus.mem_we && bus.mem_addr == 15'd1000) found = 1'b1;
        end
        check("midrst_reached", found, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_we", bus.mem_we, 0);
        check("midrst_busy", bus.clear_busy, 0);
        check("midrst_addr", bus.mem_addr, 0);
        tick();
        check("midrst_idle_we", bus.mem_we, 0);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        tick();
        check("restart_we", bus.mem_we, 1);
        check("restart_addr", bus.mem_addr, 0);
        check("restart_busy", bus.clear_busy, 1);
        n_busy = 1;
        found  = 1'b0;
        for (int k = 0; k < 5000 && !found; k++) begin
            tick();
            if (!bus.clear_busy) found = 1'b1;
            else n_busy++;
        end
        check("restart_done", found, 1);
        check("restart_busy_cycles", n_busy, 4800);
        check("restart_last_addr", bus.mem_addr, 4799);

`ifdef FB_WR_VBLANK_GATE_EN
        // Gated: no grant while vblank is low.
        bus.vblank = 1'b0;
        bus.req_a = 1'b1; bus.addr_a = 15'd77; bus.data_a = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("vb_no_gnt", bus.gnt_a, 0);
        end
        bus.vblank = 1'b1;
        tick();
        check("vb_gnt_a", bus.gnt_a, 1);
        bus.req_a = 1'b0;
        bus.vblank = 1'b0;         // write already granted must still land
        tick();
        check("vb_write_lands", bus.mem_we, 1);
        check("vb_write_addr", bus.mem_addr, 77);
        bus.vblank = 1'b1;
        tick();

        // Gated clear freezes at 500 while vblank is low.
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 700 && !found; k++) begin
            tick();
            if (bus.mem_we && bus.mem_addr == 15'd500) found = 1'b1;
        end
        check("vb_clr_reached", found, 1);
        bus.vblank = 1'b0;
        freeze_err = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.mem_we || bus.mem_addr != 15'd500 || !bus.clear_busy) freeze_err++;
        end
        check("vb_clr_freeze", freeze_err, 0);
        bus.vblank = 1'b1;
        tick();
        check("vb_clr_resume_we", bus.mem_we, 1);
        check("vb_clr_resume_addr", bus.mem_addr, 501);
        found = 1'b0;
        for (int k = 0; k < 5000 && !found; k++) begin
            tick();
            if (!bus.clear_busy) found = 1'b1;
        end
        check("vb_clr_done", found, 1);
        check("vb_clr_last_addr", bus.mem_addr, 4799);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
